// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared Morse letter codes, table constants and FSM states
package morse_pkg;

  // Clocks per Morse time unit at 50 MHz (0.5 s)
  localparam int DEFAULT_UNIT_CLKS = 25000000;

  // Letter codes, identical to the transmitter's SW[2:0] letter selection
  localparam logic [2:0] CODE_A = 3'd0;
  localparam logic [2:0] CODE_B = 3'd1;
  localparam logic [2:0] CODE_C = 3'd2;
  localparam logic [2:0] CODE_D = 3'd3;
  localparam logic [2:0] CODE_E = 3'd4;
  localparam logic [2:0] CODE_F = 3'd5;
  localparam logic [2:0] CODE_G = 3'd6;
  localparam logic [2:0] CODE_H = 3'd7;

  // Letter table: symbol count and pattern (MSB-first, 1 = dash, right-justified)
  localparam logic [2:0] LEN_A = 3'd2;  localparam logic [3:0] PAT_A = 4'b0001;
  localparam logic [2:0] LEN_B = 3'd4;  localparam logic [3:0] PAT_B = 4'b1000;
  localparam logic [2:0] LEN_C = 3'd4;  localparam logic [3:0] PAT_C = 4'b1010;
  localparam logic [2:0] LEN_D = 3'd3;  localparam logic [3:0] PAT_D = 4'b0100;
  localparam logic [2:0] LEN_E = 3'd1;  localparam logic [3:0] PAT_E = 4'b0000;
  localparam logic [2:0] LEN_F = 3'd4;  localparam logic [3:0] PAT_F = 4'b0010;
  localparam logic [2:0] LEN_G = 3'd3;  localparam logic [3:0] PAT_G = 4'b0110;
  localparam logic [2:0] LEN_H = 3'd4;  localparam logic [3:0] PAT_H = 4'b0000;

  // Longest letter the pattern register can hold
  localparam logic [2:0] MAX_SYMS = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/morse_lookup.sv
// rtl/morse_lookup.sv - combinational {length, pattern} to letter code lookup
module morse_lookup
  import morse_pkg::*;
(
  input  logic [2:0] len_i,
  input  logic [3:0] pattern_i,
  output logic [2:0] code_o,
  output logic       valid_o
);

  // Exact match on length and pattern; unused upper pattern bits must be zero
  always_comb begin
    code_o  = 3'd0;
    valid_o = 1'b0;
    case ({len_i, pattern_i})
      {LEN_A, PAT_A}: begin code_o = CODE_A; valid_o = 1'b1; end
      {LEN_B, PAT_B}: begin code_o = CODE_B; valid_o = 1'b1; end
      {LEN_C, PAT_C}: begin code_o = CODE_C; valid_o = 1'b1; end
      {LEN_D, PAT_D}: begin code_o = CODE_D; valid_o = 1'b1; end
      {LEN_E, PAT_E}: begin code_o = CODE_E; valid_o = 1'b1; end
      {LEN_F, PAT_F}: begin code_o = CODE_F; valid_o = 1'b1; end
      {LEN_G, PAT_G}: begin code_o = CODE_G; valid_o = 1'b1; end
      {LEN_H, PAT_H}: begin code_o = CODE_H; valid_o = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/morse_decoder.sv
// rtl/morse_decoder.sv - times a hand-keyed Morse input and decodes letters A-H
module morse_decoder #(
  parameter int UNIT_CLKS  = morse_pkg::DEFAULT_UNIT_CLKS,
  parameter int DASH_UNITS = 2,
  parameter int GAP_UNITS  = 2,
  parameter int CNT_W      = 28
) (
  input  logic       CLOCK_50,
  input  logic [1:0] KEY,
  output logic [7:0] LEDG,
  output logic [1:0] LEDR
);
  import morse_pkg::*;

  localparam int DASH_MIN = DASH_UNITS * UNIT_CLKS;
  localparam int GAP_MIN  = GAP_UNITS * UNIT_CLKS;
  localparam int SAT_MAX  = (DASH_MIN > GAP_MIN) ? DASH_MIN : GAP_MIN;

  // The counter starts at 0 in the cycle after the edge that entered the
  // state, so the edge cycle itself is not counted: a press of N cycles
  // leaves N-1 in the counter at release, and a gap reaches GAP_MIN zero
  // cycles (release cycle included) when the SPACE counter reads GAP_MIN-2.
  localparam logic [CNT_W-1:0] DASH_THR = CNT_W'(DASH_MIN - 1);
  localparam logic [CNT_W-1:0] GAP_THR  = CNT_W'(GAP_MIN - 2);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SAT_MAX);

  logic rst_n;
  assign rst_n = KEY[0];

  logic             sync1_q, key_s_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       pat_q, pat_d;
  logic [2:0]       sym_q, sym_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       code_q, code_d;
  logic [2:0]       len_q, len_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic [2:0]       lk_code;
  logic             lk_valid;

  morse_lookup u_lookup (
    .len_i     (sym_q),
    .pattern_i (pat_q),
    .code_o    (lk_code),
    .valid_o   (lk_valid)
  );

  // Two-flop synchronizer of the active-low Morse key
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      key_s_q <= 1'b0;
    end else begin
      sync1_q <= ~KEY[1];
      key_s_q <= sync1_q;
    end
  end

  // State, duration counter, symbol collection and latched result registers
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= 4'd0;
      sym_q   <= 3'd0;
      ovf_q   <= 1'b0;
      code_q  <= 3'd0;
      len_q   <= 3'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      sym_q   <= sym_d;
      ovf_q   <= ovf_d;
      code_q  <= code_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; the result is latched on entry to DONE so that it is
  // already on the LEDs during the strobe cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q < CNT_SAT) ? cnt_q + 1'b1 : cnt_q;
    pat_d   = pat_q;
    sym_d   = sym_q;
    ovf_d   = ovf_q;
    code_d  = code_q;
    len_d   = len_q;
    valid_d = valid_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (key_s_q) begin
          state_d = MARK;
          valid_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      MARK: begin
        if (!key_s_q) begin
          state_d = SPACE;
          if (sym_q == MAX_SYMS) begin
            ovf_d = 1'b1;
          end else begin
            pat_d = {pat_q[2:0], (cnt_q >= DASH_THR)};
            sym_d = sym_q + 3'd1;
          end
        end
      end
      SPACE: begin
        if (key_s_q) begin
          state_d = MARK;
        end else if (cnt_q >= GAP_THR) begin
          state_d = DONE;
          len_d   = sym_q;
          if (lk_valid && !ovf_q) begin
            code_d  = lk_code;
            valid_d = 1'b1;
            err_d   = 1'b0;
          end else begin
            code_d  = 3'd0;
            valid_d = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        pat_d   = 4'd0;
        sym_d   = 3'd0;
        ovf_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  assign LEDG = {(state_q == DONE), len_q, valid_q, code_q};
  assign LEDR = {key_s_q, err_q};

endmodule

// File: doc/morse_decoder.md
Name: morse_decoder

Overview:
Receive-side counterpart of the lab's Morse letter transmitter. Samples a hand-keyed Morse signal on a pushbutton and times each press as a dot or dash. Detects the inter-letter gap and decodes the collected 1-4 symbols into the 3-bit letter code A-H, using the same code as the SW[2:0] letter selection. Drives the result to the DE2 green LEDs, and drives error and key-echo status to the red LEDs.

Parameters:
UNIT_CLKS, 25000000, clocks per Morse time unit (0.5 s at 50 MHz); the bench overrides it to 10
DASH_UNITS, 2, a press of at least DASH_UNITS*UNIT_CLKS clocks is a dash; anything shorter is a dot
GAP_UNITS, 2, a release of at least GAP_UNITS*UNIT_CLKS clocks ends the letter
CNT_W, 28, width of the duration counter; must hold max(DASH_UNITS,GAP_UNITS)*UNIT_CLKS

Ports:
CLOCK_50  input  1  system clock, 50 MHz
KEY  input  2  KEY[0]: reset, asynchronous, active-low (ResetN); KEY[1]: Morse key, active-low, pressed = 0
LEDG  output  8  [2:0] decoded letter code (A=000 ... H=111); [3] letter_valid; [6:4] symbol count of the last letter; [7] letter strobe (1 cycle)
LEDR  output  2  [0] decode error (level); [1] synchronized key echo (1 = pressed)

Behaviour:
- Input conditioning: key_s is a 2-flop synchronizer of ~KEY[1]. All timing uses key_s. Latency is 2 cycles.
- Reset (KEY[0]=0, asynchronous, at any time, including mid-letter): state=IDLE, duration counter=0, symbol count=0, shift pattern=0. LEDG=8'h00, LEDR=2'b00, synchronizer flops=0.
- Duration counter: clears on every state change. Increments once per cycle while in MARK or SPACE. Saturates at max(DASH_MIN,GAP_MIN), where DASH_MIN=DASH_UNITS*UNIT_CLKS and GAP_MIN=GAP_UNITS*UNIT_CLKS. It never wraps.
- Pattern register: 4 bits, MSB-first, 1=dash. A symbol is shifted in at bit [0] with a left shift. sym_cnt is 3 bits, range 0-4. ovf flag is set when a 5th symbol arrives.
- FSM states:
  - IDLE: key_s=1 -> MARK. LEDG[3] and LEDR[0] clear on this transition, because a new letter starts.
  - MARK: count counts consecutive key_s=1 cycles. On key_s=0 -> SPACE and record the symbol: dash if count>=DASH_MIN, else dot. If sym_cnt==4, set ovf and do not shift.
  - SPACE: key_s=1 before the gap completes -> MARK (next symbol of the same letter). key_s=0 for GAP_MIN consecutive cycles -> DONE.
  - DONE (1 cycle): look up {sym_cnt, pattern}, pulse LEDG[7], latch the result, clear sym_cnt/pattern/ovf, -> IDLE.
- Letter table (length, pattern right-justified):
  - A=2,01
  - B=4,1000
  - C=4,1010
  - D=3,100
  - E=1,0
  - F=4,0010
  - G=3,110
  - H=4,0000
- DONE result, valid letter: LEDG[2:0]=code, LEDG[3]=1, LEDR[0]=0.
- DONE result, ovf or pattern not in table: LEDG[2:0]=000, LEDG[3]=0, LEDR[0]=1.
- LEDG[6:4] always latches sym_cnt in DONE (4 on overflow).
- Outputs hold until the next IDLE->MARK transition. Exception: LEDG[7] is high only during the single DONE cycle. LEDR[1]=key_s at all times.
- Boundaries:
  - Press of exactly DASH_MIN cycles = dash; DASH_MIN-1 = dot.
  - Gap of GAP_MIN-1 cycles followed by a press continues the same letter.
  - Key held indefinitely: counter saturates and the symbol stays a dash when released.
  - A 1-cycle glitch press is still a dot (no debounce in this block).
- Strobe timing: LEDG[7] is high in the cycle after key_s has been 0 for GAP_MIN consecutive cycles in SPACE.

Decomposition:
- Shared package morse_pkg:
  - letter code constants (the same ones the encoder uses)
  - letter table as length/pattern constants
  - state encoding IDLE/MARK/SPACE/DONE
  - default UNIT_CLKS
- Sub-module morse_lookup: purely combinational {len[2:0], pattern[3:0]} -> {code[2:0], valid}. It is shared with a future table-driven encoder.

Test Plan:
(All scenarios use UNIT_CLKS=10.)
1. Reset: hold KEY[0]=0 with KEY[1] toggling -> LEDG=00, LEDR=00 throughout. Release reset; no strobe follows.
2. Letter A: press 5, release 5, press 30, release 25 -> one-cycle LEDG[7] pulse, then LEDG[2:0]=000, LEDG[3]=1, LEDG[6:4]=2, LEDR[0]=0.
3. Letter C: dash-dot-dash-dot with presses 25/8/25/8 and gaps 10 -> LEDG[2:0]=010, LEDG[6:4]=4. A press of exactly 20 cycles decodes as a dash; a press of 19 cycles decodes as a dot (checked via D vs. H discrimination).
4. Gap boundary: dot, gap 19, dot -> decoded as a single 2-symbol letter, which is an error (".." is not in the table), so LEDR[0]=1. Dot, gap 20, dot -> E strobed, then a second E strobed.
5. Overflow: 5 dots with 10-cycle gaps -> LEDR[0]=1, LEDG[3]=0, LEDG[6:4]=4. The next valid E press sequence clears LEDR[0] on its first press.
6. Reset mid-letter: assert KEY[0] during the 2nd symbol of B -> all outputs 0 and no strobe. After release, a fresh E decodes correctly.
